// File: rtl/resv_dispatch_ctrl_if.sv
// Decode/station-side signal bundle for resv_dispatch_ctrl.
// The per-pipe dispatch counters exist only when RESV_DISP_PERF_EN is defined.
interface resv_dispatch_ctrl_if #(
  parameter int W_CNT = 8
);
  logic DFI_PV_instr;
  logic DFI_PD_pip;
  logic CFO_PC_ready;
  logic CFI_PC_full0;
  logic CFI_PC_full1;
  logic CFI_PC_flush;
  logic CFO_PC_ena0;
  logic CFO_PC_ena1;
  logic CFO_PC_stall0;
  logic CFO_PC_stall1;
  logic CFO_PC_clear;
  logic CFO_PC_busy;
  logic CFO_PC_hang;
`ifdef RESV_DISP_PERF_EN
  logic [W_CNT-1:0] CDO_PD_cnt0;
  logic [W_CNT-1:0] CDO_PD_cnt1;

  modport master (
    output DFI_PV_instr, DFI_PD_pip, CFI_PC_full0, CFI_PC_full1, CFI_PC_flush,
    input  CFO_PC_ready, CFO_PC_ena0, CFO_PC_ena1, CFO_PC_stall0, CFO_PC_stall1,
    input  CFO_PC_clear, CFO_PC_busy, CFO_PC_hang, CDO_PD_cnt0, CDO_PD_cnt1
  );
  modport slave (
    input  DFI_PV_instr, DFI_PD_pip, CFI_PC_full0, CFI_PC_full1, CFI_PC_flush,
    output CFO_PC_ready, CFO_PC_ena0, CFO_PC_ena1, CFO_PC_stall0, CFO_PC_stall1,
    output CFO_PC_clear, CFO_PC_busy, CFO_PC_hang, CDO_PD_cnt0, CDO_PD_cnt1
  );
`else
  modport master (
    output DFI_PV_instr, DFI_PD_pip, CFI_PC_full0, CFI_PC_full1, CFI_PC_flush,
    input  CFO_PC_ready, CFO_PC_ena0, CFO_PC_ena1, CFO_PC_stall0, CFO_PC_stall1,
    input  CFO_PC_clear, CFO_PC_busy, CFO_PC_hang
  );
  modport slave (
    input  DFI_PV_instr, DFI_PD_pip, CFI_PC_full0, CFI_PC_full1, CFI_PC_flush,
    output CFO_PC_ready, CFO_PC_ena0, CFO_PC_ena1, CFO_PC_stall0, CFO_PC_stall1,
    output CFO_PC_clear, CFO_PC_busy, CFO_PC_hang
  );
`endif
endinterface

// File: rtl/resv_dispatch_ctrl.sv
// Dispatch controller: steers decoded instructions to two reservation stations,
// sequences the flush clear, and flags blocked pipes. RESV_DISP_PERF_EN adds per-pipe dispatch counters.
module resv_dispatch_ctrl #(
  parameter int CLR_CYC   = 2,
  parameter int W_CLR     = 4,
  parameter int STALL_LIM = 15,
  parameter int W_STL     = 4,
  parameter int W_CNT     = 8
) (
  input logic                 clk,
  input logic                 CFI_PC_rst_n,
  resv_dispatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam logic [W_CLR-1:0] CLR_LAST = W_CLR'(CLR_CYC - 1);
  localparam logic [W_STL-1:0] STL_MAX  = W_STL'(STALL_LIM);

  state_e           state_q, state_d;
  logic [W_CLR-1:0] clr_cnt_q, clr_cnt_d;
  logic [W_STL-1:0] stl0_q, stl0_d, stl1_q, stl1_d;
  logic             hang_q, hang_d;

  logic go, full_sel, ready, blk0, blk1, in_run;

  // Flush wins over dispatch in the same cycle by gating go.
  assign in_run   = (state_q == ST_RUN);
  assign go       = in_run & ~bus.CFI_PC_flush;
  assign full_sel = bus.DFI_PD_pip ? bus.CFI_PC_full1 : bus.CFI_PC_full0;
  assign ready    = go & bus.DFI_PV_instr & ~full_sel;
  assign blk0     = bus.DFI_PV_instr & ~bus.DFI_PD_pip & bus.CFI_PC_full0;
  assign blk1     = bus.DFI_PV_instr &  bus.DFI_PD_pip & bus.CFI_PC_full1;

  assign bus.CFO_PC_ready  = ready;
  assign bus.CFO_PC_ena0   = ready & ~bus.DFI_PD_pip;
  assign bus.CFO_PC_ena1   = ready &  bus.DFI_PD_pip;
  assign bus.CFO_PC_stall0 = ~go | blk0;
  assign bus.CFO_PC_stall1 = ~go | blk1;
  assign bus.CFO_PC_clear  = (state_q == ST_FLUSH);
  assign bus.CFO_PC_busy   = ~in_run;
  assign bus.CFO_PC_hang   = hang_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path holds a value and infers a latch.
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_RUN, ST_RECOVER: begin
        if (bus.CFI_PC_flush) begin
          state_d   = ST_FLUSH;
          clr_cnt_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus.CFI_PC_flush) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q < CLR_LAST) begin
          clr_cnt_d = clr_cnt_q + W_CLR'(1);
        end else begin
          state_d = ST_RECOVER;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Blocked counters only run while dispatch could otherwise proceed.
  always_comb begin
    stl0_d = '0;
    stl1_d = '0;
    if (in_run && blk0) stl0_d = (stl0_q == STL_MAX) ? stl0_q : stl0_q + W_STL'(1);
    if (in_run && blk1) stl1_d = (stl1_q == STL_MAX) ? stl1_q : stl1_q + W_STL'(1);
    hang_d = hang_q | (stl0_d == STL_MAX) | (stl1_d == STL_MAX);
  end

  always_ff @(posedge clk or negedge CFI_PC_rst_n) begin
    if (!CFI_PC_rst_n) begin
      state_q   <= ST_RUN;
      clr_cnt_q <= '0;
      stl0_q    <= '0;
      stl1_q    <= '0;
      hang_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      stl0_q    <= stl0_d;
      stl1_q    <= stl1_d;
      hang_q    <= hang_d;
    end
  end

`ifdef RESV_DISP_PERF_EN
  logic [W_CNT-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge CFI_PC_rst_n) begin
    if (!CFI_PC_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (bus.CFO_PC_ena0) cnt0_q <= cnt0_q + W_CNT'(1);
      if (bus.CFO_PC_ena1) cnt1_q <= cnt1_q + W_CNT'(1);
    end
  end

  assign bus.CDO_PD_cnt0 = cnt0_q;
  assign bus.CDO_PD_cnt1 = cnt1_q;
`endif

endmodule
